// File: rtl/fft8_frame_sequencer.sv
// Frame sequencer for the 8-point FFT core: loads 8 samples, starts the core,
// watches for completion with a watchdog, then streams the 8 bins out in natural order.
module fft8_frame_sequencer #(
  parameter int IN_W         = 8,
  parameter int OUT_W        = 11,
  parameter int BITREV_OUT   = 0,
  parameter int CORE_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_real,
  input  logic [IN_W-1:0]         s_imag,
  output logic                    core_wr_en,
  output logic [2:0]              core_wr_idx,
  output logic [IN_W-1:0]         core_wr_real,
  output logic [IN_W-1:0]         core_wr_imag,
  output logic                    core_go,
  input  logic                    core_done,
  output logic [2:0]              core_rd_idx,
  input  logic [OUT_W-1:0]        core_rd_real,
  input  logic [OUT_W-1:0]        core_rd_imag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUT_W-1:0]        m_real,
  output logic [OUT_W-1:0]        m_imag,
  output logic [2:0]              m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [15:0]             frame_cnt
);

  localparam int WAIT_W = $clog2(CORE_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CORE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_KICK  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          ld_cnt_q, ld_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]          iss_q, iss_d;
  logic [3:0]          acc_q, acc_d;
  logic                s_ready_q, s_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [2:0]          wr_idx_q, wr_idx_d;
  logic [IN_W-1:0]     wr_real_q, wr_real_d;
  logic [IN_W-1:0]     wr_imag_q, wr_imag_d;
  logic                go_q, go_d;
  logic                m_valid_q, m_valid_d;
  logic [OUT_W-1:0]    m_real_q, m_real_d;
  logic [OUT_W-1:0]    m_imag_q, m_imag_d;
  logic [2:0]          m_index_q, m_index_d;
  logic                m_last_q, m_last_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [15:0]         frame_q, frame_d;

  logic s_hs;
  logic m_load;
  logic m_acc;

  assign s_hs   = s_valid && s_ready_q;
  // A new bin may enter the output register whenever it is empty or being drained.
  assign m_load = (state_q == ST_DRAIN) && !iss_q[3] && (!m_valid_q || m_ready);
  assign m_acc  = m_valid_q && m_ready;

  assign core_rd_idx = (BITREV_OUT != 0) ? bitrev3(iss_q[2:0]) : iss_q[2:0];

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    wait_cnt_d = wait_cnt_q;
    iss_d      = iss_q;
    acc_d      = acc_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_real_d  = wr_real_q;
    wr_imag_d  = wr_imag_q;
    go_d       = 1'b0;
    m_valid_d  = m_valid_q;
    m_real_d   = m_real_q;
    m_imag_d   = m_imag_q;
    m_index_d  = m_index_q;
    m_last_d   = m_last_q;
    err_d      = err_q;
    frame_d    = frame_q;

    case (state_q)
      ST_LOAD: begin
        if (s_hs) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = ld_cnt_q;
          wr_real_d = s_real;
          wr_imag_d = s_imag;
          ld_cnt_d  = ld_cnt_q + 3'd1;
          if (ld_cnt_q == 3'd7) begin
            state_d = ST_KICK;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          ld_cnt_d = ld_cnt_q;
        end
      end
      ST_KICK: begin
        go_d       = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          iss_d   = 4'd0;
          acc_d   = 4'd0;
          state_d = ST_DRAIN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d    = 1'b1;
          ld_cnt_d = 3'd0;
          state_d  = ST_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (m_load) begin
          m_valid_d = 1'b1;
          m_real_d  = core_rd_real;
          m_imag_d  = core_rd_imag;
          m_index_d = iss_q[2:0];
          m_last_d  = (iss_q == 4'd7);
          iss_d     = iss_q + 4'd1;
        end else if (m_acc) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end else begin
          m_valid_d = m_valid_q;
        end
        if (m_acc) begin
          acc_d = acc_q + 4'd1;
          if (acc_q == 4'd7) begin
            // Final bin taken: frame complete, back to loading.
            frame_d  = frame_q + 16'd1;
            iss_d    = 4'd0;
            acc_d    = 4'd0;
            ld_cnt_d = 3'd0;
            state_d  = ST_LOAD;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    busy_d    = (state_d != ST_LOAD) || (ld_cnt_d != 3'd0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      ld_cnt_q   <= 3'd0;
      wait_cnt_q <= '0;
      iss_q      <= 4'd0;
      acc_q      <= 4'd0;
      s_ready_q  <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= 3'd0;
      wr_real_q  <= '0;
      wr_imag_q  <= '0;
      go_q       <= 1'b0;
      m_valid_q  <= 1'b0;
      m_real_q   <= '0;
      m_imag_q   <= '0;
      m_index_q  <= 3'd0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      iss_q      <= iss_d;
      acc_q      <= acc_d;
      s_ready_q  <= s_ready_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_real_q  <= wr_real_d;
      wr_imag_q  <= wr_imag_d;
      go_q       <= go_d;
      m_valid_q  <= m_valid_d;
      m_real_q   <= m_real_d;
      m_imag_q   <= m_imag_d;
      m_index_q  <= m_index_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign core_wr_en   = wr_en_q;
  assign core_wr_idx  = wr_idx_q;
  assign core_wr_real = wr_real_q;
  assign core_wr_imag = wr_imag_q;
  assign core_go      = go_q;
  assign m_valid      = m_valid_q;
  assign m_real       = m_real_q;
  assign m_imag       = m_imag_q;
  assign m_index      = m_index_q;
  assign m_last       = m_last_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Directed bench: two sequencers (natural and bit-reversed core addressing) driven in
// lockstep against a small FFT-core stand-in whose bin k holds (10k, -k).
module tb_fft8_frame_sequencer;

  logic clk;
  logic rst_n;
  logic s_valid;
  logic m_ready;
  logic core_done;
  logic done_en;
  logic signed [7:0] s_real, s_imag;

  logic              s_ready   [2];
  logic              wr_en     [2];
  logic              core_go   [2];
  logic              m_valid   [2];
  logic              m_last    [2];
  logic              busy      [2];
  logic              err       [2];
  logic [2:0]        wr_idx    [2];
  logic [2:0]        rd_idx    [2];
  logic [2:0]        used_rd   [2];
  logic [2:0]        m_index   [2];
  logic signed [7:0] wr_real   [2];
  logic signed [7:0] wr_imag   [2];
  logic signed [10:0] rd_real  [2];
  logic signed [10:0] rd_imag  [2];
  logic signed [10:0] m_real   [2];
  logic signed [10:0] m_imag   [2];
  logic [15:0]       frame_cnt [2];
  logic [2:0]        done_sr;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [7:0] re;
    logic signed [7:0] im;
    logic [2:0]        idx;
  } lv_t;

  typedef struct {
    logic rdy;
    logic vld;
    int   k;
  } dv_t;

  lv_t lv [8];
  dv_t dv [25];

  function automatic logic [2:0] br3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [2:0] bin_k;
    assign bin_k      = (g == 1) ? br3(rd_idx[g]) : rd_idx[g];
    assign rd_real[g] = 11'(10 * int'(bin_k));
    assign rd_imag[g] = 11'(-int'(bin_k));

    fft8_frame_sequencer #(
      .IN_W(8), .OUT_W(11), .BITREV_OUT(g), .CORE_TIMEOUT(16)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready[g]), .s_real(s_real), .s_imag(s_imag),
      .core_wr_en(wr_en[g]), .core_wr_idx(wr_idx[g]),
      .core_wr_real(wr_real[g]), .core_wr_imag(wr_imag[g]),
      .core_go(core_go[g]), .core_done(core_done),
      .core_rd_idx(rd_idx[g]), .core_rd_real(rd_real[g]), .core_rd_imag(rd_imag[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready), .m_real(m_real[g]), .m_imag(m_imag[g]),
      .m_index(m_index[g]), .m_last(m_last[g]),
      .busy(busy[g]), .err_timeout(err[g]), .frame_cnt(frame_cnt[g])
    );
  end

  // Core stand-in: done pulse three cycles after go.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_sr <= 3'd0;
    else        done_sr <= {done_sr[1:0], core_go[0] & done_en};
  end
  assign core_done = done_sr[2];

  // Address each sequencer presented to the core at the last clock edge.
  always @(posedge clk) begin
    used_rd[0] <= rd_idx[0];
    used_rd[1] <= rd_idx[1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_frame();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("d%0d wr_en s%0d", d, i - 1), wr_en[d], 1);
          chk($sformatf("d%0d wr_idx s%0d", d, i - 1), wr_idx[d], int'(lv[i-1].idx));
          chk($sformatf("d%0d wr_real s%0d", d, i - 1), wr_real[d], int'(lv[i-1].re));
          chk($sformatf("d%0d wr_imag s%0d", d, i - 1), wr_imag[d], int'(lv[i-1].im));
        end
      end
      if (i < 8) begin
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d s_ready load", d), s_ready[d], 1);
        s_valid = 1'b1;
        s_real  = lv[i].re;
        s_imag  = lv[i].im;
      end else begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("d%0d s_ready kick", d), s_ready[d], 0);
          chk($sformatf("d%0d go early", d), core_go[d], 0);
        end
        s_real = 8'sd99;
        s_imag = 8'sd99;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d go", d), core_go[d], 1);
      chk($sformatf("d%0d wr_en after kick", d), wr_en[d], 0);
      chk($sformatf("d%0d s_ready wait", d), s_ready[d], 0);
      chk($sformatf("d%0d busy wait", d), busy[d], 1);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d go single", d), core_go[d], 0);
    s_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first bin latency", n, 4);
  endtask

  task automatic run_drain(input int start, input int len, input int exp_frames);
    wait_valid();
    for (int r = start; r < start + len; r++) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d m_valid r%0d", d, r), m_valid[d], int'(dv[r].vld));
        chk($sformatf("d%0d s_ready r%0d", d, r), s_ready[d], int'(!dv[r].vld));
        if (dv[r].vld) begin
          chk($sformatf("d%0d m_index r%0d", d, r), m_index[d], dv[r].k);
          chk($sformatf("d%0d m_real r%0d", d, r), m_real[d], 10 * dv[r].k);
          chk($sformatf("d%0d m_imag r%0d", d, r), m_imag[d], -dv[r].k);
          chk($sformatf("d%0d m_last r%0d", d, r), m_last[d], int'(dv[r].k == 7));
          if (r == start || dv[r-1].rdy) begin
            chk($sformatf("d%0d rd_idx r%0d", d, r), used_rd[d],
                int'((d == 1) ? br3(3'(dv[r].k)) : 3'(dv[r].k)));
          end
        end
      end
      m_ready = dv[r].rdy;
      @(negedge clk);
    end
    m_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d frame_cnt", d), frame_cnt[d], exp_frames);
      chk($sformatf("d%0d s_ready idle", d), s_ready[d], 1);
      chk($sformatf("d%0d busy idle", d), busy[d], 0);
      chk($sformatf("d%0d m_valid idle", d), m_valid[d], 0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d %s s_ready", d, tag), s_ready[d], 1);
      chk($sformatf("d%0d %s wr_en", d, tag), wr_en[d], 0);
      chk($sformatf("d%0d %s go", d, tag), core_go[d], 0);
      chk($sformatf("d%0d %s m_valid", d, tag), m_valid[d], 0);
      chk($sformatf("d%0d %s m_last", d, tag), m_last[d], 0);
      chk($sformatf("d%0d %s m_real", d, tag), m_real[d], 0);
      chk($sformatf("d%0d %s m_imag", d, tag), m_imag[d], 0);
      chk($sformatf("d%0d %s m_index", d, tag), m_index[d], 0);
      chk($sformatf("d%0d %s err", d, tag), err[d], 0);
      chk($sformatf("d%0d %s frame_cnt", d, tag), frame_cnt[d], 0);
      chk($sformatf("d%0d %s busy", d, tag), busy[d], 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      lv[i] = '{8'(i + 1), 8'(-(i + 1)), 3'(i)};
      dv[i] = '{1'b1, 1'b1, i};
    end
    dv[8]  = '{1'b0, 1'b0, 0};
    // m_ready pattern 1,0,0,1,0,1,1,0 repeating, with the bin each cycle must show
    dv[9]  = '{1'b1, 1'b1, 0};
    dv[10] = '{1'b0, 1'b1, 1};
    dv[11] = '{1'b0, 1'b1, 1};
    dv[12] = '{1'b1, 1'b1, 1};
    dv[13] = '{1'b0, 1'b1, 2};
    dv[14] = '{1'b1, 1'b1, 2};
    dv[15] = '{1'b1, 1'b1, 3};
    dv[16] = '{1'b0, 1'b1, 4};
    dv[17] = '{1'b1, 1'b1, 4};
    dv[18] = '{1'b0, 1'b1, 5};
    dv[19] = '{1'b0, 1'b1, 5};
    dv[20] = '{1'b1, 1'b1, 5};
    dv[21] = '{1'b0, 1'b1, 6};
    dv[22] = '{1'b1, 1'b1, 6};
    dv[23] = '{1'b1, 1'b1, 7};
    dv[24] = '{1'b0, 1'b0, 0};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_real  = 8'sd0;
    s_imag  = 8'sd0;
    m_ready = 1'b0;
    done_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full-throughput frame, then a frame under a stalling consumer.
    load_frame();
    run_drain(0, 9, 1);
    load_frame();
    run_drain(9, 16, 2);

    // Core never finishes: watchdog fires 16 cycles into WAIT.
    done_en = 1'b0;
    load_frame();
    for (int j = 2; j <= 16; j++) begin
      @(negedge clk);
      if (j == 15) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("d%0d err before timeout", d), err[d], 0);
          chk($sformatf("d%0d s_ready before timeout", d), s_ready[d], 0);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d err timeout", d), err[d], 1);
      chk($sformatf("d%0d s_ready after timeout", d), s_ready[d], 1);
      chk($sformatf("d%0d frame after timeout", d), frame_cnt[d], 2);
      chk($sformatf("d%0d m_valid after timeout", d), m_valid[d], 0);
    end
    done_en = 1'b1;
    load_frame();
    run_drain(0, 9, 3);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d err sticky", d), err[d], 1);

    // Reset in the middle of draining, after three bins have been taken.
    load_frame();
    wait_valid();
    for (int j = 0; j < 3; j++) begin
      m_ready = 1'b1;
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d m_index before reset", d), m_index[d], 3);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid-drain reset");
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("d%0d go after reset c%0d", d, j), core_go[d], 0);
    end
    load_frame();
    run_drain(0, 9, 1);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d err after reset", d), err[d], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
